// File: rtl/prog_loader_if.sv
// Byte-stream, instruction-memory write and status bundle for prog_loader.
// master = stream source and memory side, slave = the loader itself.
interface prog_loader_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 13
);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses COUNT, HI/LO pairs and CSUM from a byte stream,
// writes {opcode, operand} words from address 0 and holds the CPU meanwhile.
module prog_loader #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 13
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);
  localparam int        OPW       = DWIDTH - 8;
  localparam int        MAX_WORDS = 2 ** AWIDTH;
  localparam logic [7:0] OP_MASK  = 8'((32'd1 << OPW) - 32'd1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_CSUM  = 3'd4
  } state_t;

  state_t            state_r;
  logic [AWIDTH-1:0] idx_r;
  logic [AWIDTH-1:0] last_r;
  logic [7:0]        sum_r;
  logic [OPW-1:0]    op_r;
  logic              in_ready_r;
  logic              wr_en_r;
  logic [AWIDTH-1:0] wr_addr_r;
  logic [DWIDTH-1:0] wr_data_r;
  logic              cpu_hold_r;
  logic              done_r;
  logic              err_r;
  logic              accept_s;

  // A set bit above the opcode field makes the HI byte malformed.
  function automatic logic hi_bad(input logic [7:0] b);
    return |(b & ~OP_MASK);
  endfunction

  // Zero encodes the full memory; anything above 2^AWIDTH is rejected.
  function automatic logic count_ok(input logic [7:0] c);
    return (c == 8'd0) || (int'(c) <= MAX_WORDS);
  endfunction

  function automatic logic [AWIDTH-1:0] last_index(input logic [7:0] c);
    logic [AWIDTH-1:0] r;
    if (c == 8'd0) r = {AWIDTH{1'b1}};
    else           r = AWIDTH'(int'(c) - 1);
    return r;
  endfunction

  function automatic logic [7:0] csum_add(input logic [7:0] s, input logic [7:0] b);
    return s + b;
  endfunction

  // Byte handshake completes this edge.
  always_comb begin
    accept_s = bus.in_valid && in_ready_r;
  end

  // Load sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      last_r     <= '0;
      sum_r      <= 8'd0;
      op_r       <= '0;
      in_ready_r <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      cpu_hold_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r    <= S_COUNT;
            err_r      <= 1'b0;
            idx_r      <= '0;
            sum_r      <= 8'd0;
            in_ready_r <= 1'b1;
            cpu_hold_r <= 1'b1;
          end
        end
        S_COUNT: begin
          if (accept_s) begin
            if (count_ok(bus.in_data)) begin
              last_r  <= last_index(bus.in_data);
              state_r <= S_HI;
            end else begin
              state_r    <= IDLE;
              err_r      <= 1'b1;
              in_ready_r <= 1'b0;
              cpu_hold_r <= 1'b0;
            end
          end
        end
        S_HI: begin
          if (accept_s) begin
            if (hi_bad(bus.in_data)) begin
              state_r    <= IDLE;
              err_r      <= 1'b1;
              in_ready_r <= 1'b0;
              cpu_hold_r <= 1'b0;
            end else begin
              op_r    <= bus.in_data[OPW-1:0];
              sum_r   <= csum_add(sum_r, bus.in_data);
              state_r <= S_LO;
            end
          end
        end
        S_LO: begin
          if (accept_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= idx_r;
            wr_data_r <= {op_r, bus.in_data};
            sum_r     <= csum_add(sum_r, bus.in_data);
            // Index wraps to zero only after the 2^AWIDTH-th word, never reused.
            if (idx_r == last_r) begin
              state_r <= S_CSUM;
            end else begin
              idx_r   <= idx_r + {{(AWIDTH-1){1'b0}}, 1'b1};
              state_r <= S_HI;
            end
          end
        end
        S_CSUM: begin
          if (accept_s) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            cpu_hold_r <= 1'b0;
            if (bus.in_data == sum_r) done_r <= 1'b1;
            else                      err_r  <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          cpu_hold_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.cpu_hold = cpu_hold_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: drivers queue expected writes/outcomes,
// a negedge monitor pops and compares whatever the loader presents.
module tb_prog_loader;
  localparam int AW = 8;
  localparam int DW = 13;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic clk;
  logic rst;

  prog_loader_if #(.AWIDTH(AW), .DWIDTH(DW)) bus();

  prog_loader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW+DW-1:0] exp_wr_q[$];
  int exp_ev_q[$];
  bit mon_en     = 1'b0;
  bit stall_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: compares every write, DONE pulse and ERR rise against the queues.
  initial begin
    logic [AW+DW-1:0] e;
    int ev;
    logic prev_err;
    int cyc;
    int last_wr_cyc;
    prev_err = 1'b0;
    cyc = 0;
    last_wr_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (bus.wr_en) begin
          last_wr_cyc = cyc;
          if (exp_wr_q.size() == 0) begin
            check("unexpected_write", {11'd0, bus.wr_addr, bus.wr_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_wr_q.pop_front();
            check("write_addr_data", {11'd0, bus.wr_addr, bus.wr_data}, {11'd0, e});
          end
        end
        if (bus.done) begin
          if (exp_ev_q.size() == 0) ev = 0;
          else ev = exp_ev_q.pop_front();
          check("done_event", 32'd1, ev);
          if (!stall_mode) check("done_after_last_write", cyc - last_wr_cyc, 32'd1);
        end
        if (bus.err && !prev_err) begin
          if (exp_ev_q.size() == 0) ev = 0;
          else ev = exp_ev_q.pop_front();
          check("err_event", 32'd2, ev);
        end
      end
      prev_err = bus.err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_in_ready", bus.in_ready, 32'd1);
    check("start_cpu_hold", bus.cpu_hold, 32'd1);
    check("start_err_clear", bus.err, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        tick();
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", 32'd0, 32'd1);
    else tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_wr_q.size() != 0 || exp_ev_q.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    check(name, exp_wr_q.size() + exp_ev_q.size(), 32'd0);
  endtask

  // Full session; the table words come from the 3-word directed stream,
  // otherwise each word equals its index.
  task automatic run_load(input logic [7:0] cnt, input int nw, input bit use_tbl,
                          input logic [7:0] csum, input int exp_ev,
                          input bit stall, input bit noise);
    logic [DW-1:0] tbl [3];
    logic [DW-1:0] w;
    logic [AW-1:0] a;
    tbl[0] = 13'h0CAE;
    tbl[1] = 13'h0100;
    tbl[2] = 13'h0504;
    stall_mode = stall;
    start_load();
    send_byte(cnt, stall);
    for (int i = 0; i < nw; i++) begin
      if (use_tbl) w = tbl[i];
      else         w = DW'(i);
      a = AW'(i);
      exp_wr_q.push_back({a, w});
      if (noise) bus.start = 1'(i % 2);
      send_byte({3'b000, w[12:8]}, stall);
      send_byte(w[7:0], stall);
    end
    bus.start = 1'b0;
    exp_ev_q.push_back(exp_ev);
    send_byte(csum, stall);
    bus.in_valid = 1'b0;
    drain("load_drain");
    check("end_cpu_hold", bus.cpu_hold, 32'd0);
    check("end_in_ready", bus.in_ready, 32'd0);
    check("end_err", bus.err, (exp_ev == EV_ERR) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.start    = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 32'd0);
    check("rst_wr_en",    bus.wr_en,    32'd0);
    check("rst_done",     bus.done,     32'd0);
    check("rst_err",      bus.err,      32'd0);
    check("rst_cpu_hold", bus.cpu_hold, 32'd0);
    check("rst_wr_addr",  bus.wr_addr,  32'd0);
    check("rst_wr_data",  bus.wr_data,  32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Good 3-word load, checksum 0x0C+0xAE+0x01+0x00+0x05+0x04 = 0xC4.
    run_load(8'h03, 3, 1'b1, 8'hC4, EV_DONE, 1'b0, 1'b0);

    // Wrong checksum: writes still land, ERR sticks until next START.
    run_load(8'h03, 3, 1'b1, 8'hC5, EV_ERR, 1'b0, 1'b0);
    repeat (5) tick();
    check("err_sticky", bus.err, 32'd1);
    run_load(8'h03, 3, 1'b1, 8'hC4, EV_DONE, 1'b0, 1'b0);

    // Bad HI byte 0x2C in word 1: only word 0 is written.
    stall_mode = 1'b0;
    start_load();
    send_byte(8'h03, 1'b0);
    exp_wr_q.push_back({8'h00, 13'h0CAE});
    send_byte(8'h0C, 1'b0);
    send_byte(8'hAE, 1'b0);
    exp_ev_q.push_back(EV_ERR);
    send_byte(8'h2C, 1'b0);
    check("badhi_err",      bus.err,      32'd1);
    check("badhi_in_ready", bus.in_ready, 32'd0);
    check("badhi_cpu_hold", bus.cpu_hold, 32'd0);
    bus.in_data = 8'h00;
    repeat (4) begin
      tick();
      check("badhi_no_accept", bus.in_ready, 32'd0);
    end
    bus.in_valid = 1'b0;
    drain("badhi_drain");

    // Reset lands on the same edge as the LO byte: nothing is written.
    start_load();
    send_byte(8'h03, 1'b0);
    send_byte(8'h0C, 1'b0);
    bus.in_data  = 8'hAE;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("midrst_in_ready", bus.in_ready, 32'd0);
    check("midrst_cpu_hold", bus.cpu_hold, 32'd0);
    check("midrst_err",      bus.err,      32'd0);
    check("midrst_wr_en",    bus.wr_en,    32'd0);
    repeat (3) tick();
    run_load(8'h03, 3, 1'b1, 8'hC4, EV_DONE, 1'b0, 1'b0);

    // Random IN_VALID gaps and START pulses while busy.
    run_load(8'h03, 3, 1'b1, 8'hC4, EV_DONE, 1'b1, 1'b1);

    // Full 256-word load, word i = i; checksum = sum(0..255) mod 256 = 0x80.
    run_load(8'h00, 256, 1'b0, 8'h80, EV_DONE, 1'b0, 1'b0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
